// File: rtl/axis_i2s2_transmitter_pkg.sv
// Shared constants, slave FSM encoding and load-point helpers for the I2S2 transmitter.
package axis_i2s2_transmitter_pkg;

    localparam int unsigned I2S_SLOT_BITS = 32;

    typedef enum logic {
        WAIT_L = 1'b0,
        WAIT_R = 1'b1
    } slave_state_e;

    // Counter value of the left-channel load: last clk of the first SCLK period.
    function automatic int unsigned load_l_cnt(input int unsigned sclk_div_log2);
        return (32'd1 << sclk_div_log2) - 32'd1;
    endfunction

    // Counter value of the right-channel load: same point, half a frame later.
    function automatic int unsigned load_r_cnt(input int unsigned sclk_div_log2);
        return (32'd1 << (sclk_div_log2 + 32'd5)) + (32'd1 << sclk_div_log2) - 32'd1;
    endfunction

endpackage

// File: rtl/axis_i2s2_transmitter_clock_gen.sv
// Free-running frame counter producing LRCK/SCLK and the bit/load strobes.
//   clk, resetn   : clock, synchronous active-low reset
//   lrck, sclk    : word select and bit clock, taken straight from counter bits
//   bit_stb_c     : last clk of every SCLK period (shift point)
//   load_l_c/_r_c : left / right shifter load points
module i2s_clock_gen
    import axis_i2s2_transmitter_pkg::*;
#(
    parameter int unsigned SCLK_DIV_LOG2 = 3
) (
    input  logic clk,
    input  logic resetn,
    output logic lrck,
    output logic sclk,
    output logic bit_stb_c,
    output logic load_l_c,
    output logic load_r_c
);

    localparam int unsigned S = SCLK_DIV_LOG2;
    localparam int unsigned W = S + 6;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) cnt <= '0;
        else         cnt <= cnt + W'(1);
    end

    assign lrck      = cnt[W-1];
    assign sclk      = cnt[S-1];
    assign bit_stb_c = &cnt[S-1:0];
    assign load_l_c  = (cnt == W'(load_l_cnt(S)));
    assign load_r_c  = (cnt == W'(load_r_cnt(S)));

endmodule

// File: rtl/axis_i2s2_transmitter.sv
// AXI-Stream stereo pair to I2S serialiser for the Pmod I2S2 DAC.
//   s_axis_*  : 2-beat packets, left (last=0) then right (last=1)
//   tx_mclk   : clk forwarded; tx_lrck/tx_sclk/tx_sdout : I2S serial interface
//   underrun  : pulse when a frame starts with no pair buffered (silence sent)
//   desync    : pulse when a beat arrives with unexpected last flag
module axis_i2s2_transmitter
    import axis_i2s2_transmitter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned SCLK_DIV_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic                  tx_mclk,
    output logic                  tx_lrck,
    output logic                  tx_sclk,
    output logic                  tx_sdout,
    output logic                  underrun,
    output logic                  desync
);

    localparam int unsigned PAD_BITS = I2S_SLOT_BITS - DATA_WIDTH;

    logic bit_stb_c, load_l_c, load_r_c;

    slave_state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0]       hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0]       hold_r_q, hold_r_d;
    logic                        hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]       frame_r_q, frame_r_d;
    logic [I2S_SLOT_BITS-1:0]    shift_q, shift_d;
    logic                        underrun_d, desync_d;
    logic                        beat_c;

    i2s_clock_gen #(
        .SCLK_DIV_LOG2(SCLK_DIV_LOG2)
    ) u_clock_gen (
        .clk       (clk),
        .resetn    (resetn),
        .lrck      (tx_lrck),
        .sclk      (tx_sclk),
        .bit_stb_c (bit_stb_c),
        .load_l_c  (load_l_c),
        .load_r_c  (load_r_c)
    );

    assign tx_mclk = clk;
    assign beat_c  = s_axis_valid & s_axis_ready;

    // Next-state: slave FSM, pair buffer, frame buffer and shifter.
    always_comb begin
        state_d      = state_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        hold_valid_d = hold_valid_q;
        frame_r_d    = frame_r_q;
        shift_d      = shift_q;
        underrun_d   = 1'b0;
        desync_d     = 1'b0;

        // Frame start takes the whole buffered pair; the left word goes straight
        // into the shifter, the right word waits in frame_r for its slot.
        if (load_l_c) begin
            if (hold_valid_q) begin
                shift_d      = {hold_l_q, {PAD_BITS{1'b0}}};
                frame_r_d    = hold_r_q;
                hold_valid_d = 1'b0;
            end else begin
                shift_d    = '0;
                frame_r_d  = '0;
                underrun_d = 1'b1;
            end
        end else if (load_r_c) begin
            shift_d = {frame_r_q, {PAD_BITS{1'b0}}};
        end else if (bit_stb_c) begin
            shift_d = {shift_q[I2S_SLOT_BITS-2:0], 1'b0};
        end

        // Beats only land while hold_valid is clear, so they never race the consume above.
        case (state_q)
            WAIT_L: begin
                if (beat_c) begin
                    if (!s_axis_last) begin
                        hold_l_d = s_axis_data;
                        state_d  = WAIT_R;
                    end else begin
                        desync_d = 1'b1;
                    end
                end
            end
            WAIT_R: begin
                if (beat_c) begin
                    if (s_axis_last) begin
                        hold_r_d     = s_axis_data;
                        hold_valid_d = 1'b1;
                        state_d      = WAIT_L;
                    end else begin
                        hold_l_d = s_axis_data;
                        desync_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_L;
        endcase
    end

    // State register; ready is registered from the next hold_valid so it stays 0 in reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= WAIT_L;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            hold_valid_q <= 1'b0;
            frame_r_q    <= '0;
            shift_q      <= '0;
            tx_sdout     <= 1'b0;
            underrun     <= 1'b0;
            desync       <= 1'b0;
            s_axis_ready <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            hold_valid_q <= hold_valid_d;
            frame_r_q    <= frame_r_d;
            shift_q      <= shift_d;
            tx_sdout     <= shift_d[I2S_SLOT_BITS-1];
            underrun     <= underrun_d;
            desync       <= desync_d;
            s_axis_ready <= ~hold_valid_d;
        end
    end

endmodule

// File: tb/tb_axis_i2s2_transmitter.sv
// Directed scoreboard bench for axis_i2s2_transmitter (DATA_WIDTH=24, SCLK_DIV_LOG2=3).
module tb_axis_i2s2_transmitter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [23:0] s_axis_data;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic        s_axis_last;
    logic        tx_mclk, tx_lrck, tx_sclk, tx_sdout, underrun, desync;

    int tests = 0;
    int fails = 0;

    logic [8:0]  tcnt = '0;
    logic [8:0]  acc;
    logic [31:0] wl = '0;
    logic [31:0] wr = '0;
    logic [63:0] rx_q[$];
    logic [63:0] exp_q[$];

    axis_i2s2_transmitter dut (
        .clk          (clk),
        .resetn       (resetn),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .tx_mclk      (tx_mclk),
        .tx_lrck      (tx_lrck),
        .tx_sclk      (tx_sclk),
        .tx_sdout     (tx_sdout),
        .underrun     (underrun),
        .desync       (desync)
    );

    always #5 clk = ~clk;

    // Reference frame position: 512 clk per frame, restarts from 0 on reset.
    always @(posedge clk) tcnt <= resetn ? tcnt + 9'd1 : 9'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected slot contents in SCLK order: delay bit, 24 sample bits, 7 pad bits.
    function automatic logic [31:0] slot(input logic [23:0] s);
        return {1'b0, s, 7'b0};
    endfunction

    function automatic logic [63:0] frame(input logic [23:0] l, input logic [23:0] r);
        return {slot(l), slot(r)};
    endfunction

    // Capture sdout on each SCLK rising half; one frame pushed per 512 clk.
    always @(negedge clk) begin
        if (!resetn) begin
            wl = '0;
            wr = '0;
        end else begin
            if (tcnt[2:0] == 3'd4) begin
                check("lrck", 32'(tx_lrck), 32'(tcnt[8]));
                check("sclk_hi", 32'(tx_sclk), 32'd1);
                if (!tcnt[8]) wl = {wl[30:0], tx_sdout};
                else          wr = {wr[30:0], tx_sdout};
            end
            if (tcnt[2:0] == 3'd0) check("sclk_lo", 32'(tx_sclk), 32'd0);
            if (tcnt == 9'd511) rx_q.push_back({wl, wr});
        end
    end

    task automatic wait_cnt(input logic [8:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tcnt != v && n < 1200);
        tests++;
        assert (tcnt == v) else begin
            fails++;
            $error("FAIL wait_cnt: observed %0d expected %0d", tcnt, v);
        end
    endtask

    task automatic send(input logic [23:0] d, input logic l, output logic [8:0] at);
        int n = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_last  = l;
        while (s_axis_ready !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        at = tcnt;
        tests++;
        assert (s_axis_ready === 1'b1) else begin
            fails++;
            $error("FAIL handshake: ready observed %b expected 1", s_axis_ready);
        end
        @(negedge clk);
        s_axis_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        logic [63:0] got, want;
        while (rx_q.size() == 0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        assert (rx_q.size() != 0) else begin
            fails++;
            $error("FAIL %s_timeout: observed no frame expected one", tag);
        end
        if (rx_q.size() != 0 && exp_q.size() != 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            check({tag, "_L"}, got[63:32], want[63:32]);
            check({tag, "_R"}, got[31:0], want[31:0]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        s_axis_last  = 1'b0;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_ready", 32'(s_axis_ready), 32'd0);
        check("rst_sdout", 32'(tx_sdout), 32'd0);
        check("rst_lrck", 32'(tx_lrck), 32'd0);
        check("rst_sclk", 32'(tx_sclk), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_desync", 32'(desync), 32'd0);
        check("mclk_low", 32'(tx_mclk), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(s_axis_ready), 32'd1);

        // No input: silent frame, underrun flagged by the cnt==7 load
        rx_q.delete();
        exp_q.push_back(64'd0);
        wait_cnt(9'd7);
        check("underrun_pre", 32'(underrun), 32'd0);
        @(negedge clk);
        check("underrun_pulse", 32'(underrun), 32'd1);
        @(negedge clk);
        check("underrun_clear", 32'(underrun), 32'd0);
        wait_frame("silent");

        // Basic pair with MSB/LSB set patterns
        wait_cnt(9'd100);
        send(24'h800001, 1'b0, acc);
        send(24'h7FFFFE, 1'b1, acc);
        check("ready_held", 32'(s_axis_ready), 32'd0);
        wait_cnt(9'd7);
        check("ready_pre_load", 32'(s_axis_ready), 32'd0);
        @(negedge clk);
        check("no_underrun", 32'(underrun), 32'd0);
        check("ready_reopen", 32'(s_axis_ready), 32'd1);
        rx_q.delete();
        exp_q.push_back(frame(24'h800001, 24'h7FFFFE));
        wait_frame("pair1");

        // Back-to-back stream of three pairs
        wait_cnt(9'd20);
        rx_q.delete();
        exp_q.push_back(64'd0);
        exp_q.push_back(frame(24'hA00001, 24'h0000A1));
        send(24'hA00001, 1'b0, acc);
        send(24'h0000A1, 1'b1, acc);
        exp_q.push_back(frame(24'hB00002, 24'h0000B2));
        send(24'hB00002, 1'b0, acc);
        check("stream_accept_p2", 32'(acc), 32'd8);
        send(24'h0000B2, 1'b1, acc);
        exp_q.push_back(frame(24'hC00003, 24'h0000C3));
        send(24'hC00003, 1'b0, acc);
        check("stream_accept_p3", 32'(acc), 32'd8);
        send(24'h0000C3, 1'b1, acc);
        wait_frame("stream_gap");
        wait_frame("stream_p1");
        wait_frame("stream_p2");
        wait_frame("stream_p3");

        // Framing violations
        wait_cnt(9'd100);
        send(24'hABCDEF, 1'b1, acc);
        check("desync_lone_r", 32'(desync), 32'd1);
        @(negedge clk);
        check("desync_clear", 32'(desync), 32'd0);
        check("ready_after_drop", 32'(s_axis_ready), 32'd1);
        send(24'h111111, 1'b0, acc);
        check("desync_first_l", 32'(desync), 32'd0);
        send(24'h222222, 1'b0, acc);
        check("desync_double_l", 32'(desync), 32'd1);
        send(24'h333333, 1'b1, acc);
        wait_cnt(9'd8);
        check("desync_no_underrun", 32'(underrun), 32'd0);
        rx_q.delete();
        exp_q.push_back(frame(24'h222222, 24'h333333));
        wait_frame("desync_pair");

        // Right word completes in the left-load cycle
        wait_cnt(9'd400);
        send(24'h0F0F0F, 1'b0, acc);
        wait_cnt(9'd7);
        send(24'hF0F0F0, 1'b1, acc);
        check("late_r_underrun", 32'(underrun), 32'd1);
        check("late_r_ready", 32'(s_axis_ready), 32'd0);
        rx_q.delete();
        exp_q.push_back(64'd0);
        exp_q.push_back(frame(24'h0F0F0F, 24'hF0F0F0));
        wait_frame("late_silent");
        wait_frame("late_pair");

        // Reset mid-frame with half a pair held
        wait_cnt(9'd200);
        send(24'hC00000, 1'b0, acc);
        send(24'hFFFFFF, 1'b1, acc);
        wait_cnt(9'd20);
        send(24'h5A5A5A, 1'b0, acc);
        wait_cnt(9'd300);
        check("sdout_before_rst", 32'(tx_sdout), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_sdout", 32'(tx_sdout), 32'd0);
        check("midrst_lrck", 32'(tx_lrck), 32'd0);
        check("midrst_ready", 32'(s_axis_ready), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        wait_cnt(9'd100);
        send(24'h123456, 1'b0, acc);
        check("post_rst_desync", 32'(desync), 32'd0);
        send(24'h654321, 1'b1, acc);
        wait_cnt(9'd8);
        rx_q.delete();
        exp_q.push_back(frame(24'h123456, 24'h654321));
        wait_frame("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
